// File: rtl/sobel_edge_detect.sv
// Sobel edge detector: pads the incoming 3x3 window at image borders, computes |Gx|+|Gy|,
// thresholds it into a binary edge map and counts edge pixels per frame. Four-cycle latency.
module sobel_edge_detect #(
  parameter logic [7:0]  DEFAULT_THRESH = 8'd80,
  parameter int unsigned CNT_W          = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             matrix_img_vsync,
  input  logic             matrix_img_href,
  input  logic             matrix_top_edge_flag,
  input  logic             matrix_bottom_edge_flag,
  input  logic             matrix_left_edge_flag,
  input  logic             matrix_right_edge_flag,
  input  logic [7:0]       matrix_p11,
  input  logic [7:0]       matrix_p12,
  input  logic [7:0]       matrix_p13,
  input  logic [7:0]       matrix_p21,
  input  logic [7:0]       matrix_p22,
  input  logic [7:0]       matrix_p23,
  input  logic [7:0]       matrix_p31,
  input  logic [7:0]       matrix_p32,
  input  logic [7:0]       matrix_p33,
  input  logic [7:0]       threshold,
  output logic             post_img_vsync,
  output logic             post_img_href,
  output logic [7:0]       post_img_mag,
  output logic             post_img_bit,
  output logic [CNT_W-1:0] edge_count,
  output logic             edge_count_valid
);

  // Sync delay lines: index 0 is aligned with stage 1, index 3 with the outputs.
  logic [3:0] vs_q, vs_d, hr_q, hr_d;

  logic [7:0] thr_q, thr_d;

  logic [8:0][7:0] rp;  // row-padded window, index = row*3 + col
  logic [7:0] w11_q, w12_q, w13_q, w21_q, w23_q, w31_q, w32_q, w33_q;
  logic [7:0] w11_d, w12_d, w13_d, w21_d, w23_d, w31_d, w32_d, w33_d;

  logic [10:0] gx_q, gx_d, gy_q, gy_d;
  logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [10:0] abs_x, abs_y;
  logic [10:0] sum_q, sum_d;

  logic [7:0] mag_q, mag_d;
  logic       bit_q, bit_d;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, ec_q, ec_d;
  logic             ecv_q, ecv_d, pvs_q, pvs_d;
  logic             inc, fall;

  always_comb begin
    vs_d  = {vs_q[2:0], matrix_img_vsync};
    hr_d  = {hr_q[2:0], matrix_img_href};
    thr_d = (vs_q[0] && !vs_q[1]) ? threshold : thr_q;
  end

  // Stage 1: rows are replaced first, columns second, so corners pick up the centre value.
  always_comb begin
    rp[0] = matrix_top_edge_flag    ? matrix_p21 : matrix_p11;
    rp[1] = matrix_top_edge_flag    ? matrix_p22 : matrix_p12;
    rp[2] = matrix_top_edge_flag    ? matrix_p23 : matrix_p13;
    rp[3] = matrix_p21;
    rp[4] = matrix_p22;
    rp[5] = matrix_p23;
    rp[6] = matrix_bottom_edge_flag ? matrix_p21 : matrix_p31;
    rp[7] = matrix_bottom_edge_flag ? matrix_p22 : matrix_p32;
    rp[8] = matrix_bottom_edge_flag ? matrix_p23 : matrix_p33;
  end

  always_comb begin
    w11_d = matrix_left_edge_flag  ? rp[1] : rp[0];
    w12_d = rp[1];
    w13_d = matrix_right_edge_flag ? rp[1] : rp[2];
    w21_d = matrix_left_edge_flag  ? rp[4] : rp[3];
    w23_d = matrix_right_edge_flag ? rp[4] : rp[5];
    w31_d = matrix_left_edge_flag  ? rp[7] : rp[6];
    w32_d = rp[7];
    w33_d = matrix_right_edge_flag ? rp[7] : rp[8];
  end

  // Stage 2: gradients held as 11-bit two's complement.
  always_comb begin
    gx_pos = 11'(w13_q) + {2'b00, w23_q, 1'b0} + 11'(w33_q);
    gx_neg = 11'(w11_q) + {2'b00, w21_q, 1'b0} + 11'(w31_q);
    gy_pos = 11'(w31_q) + {2'b00, w32_q, 1'b0} + 11'(w33_q);
    gy_neg = 11'(w11_q) + {2'b00, w12_q, 1'b0} + 11'(w13_q);
    gx_d   = gx_pos - gx_neg;
    gy_d   = gy_pos - gy_neg;
  end

  // Stage 3
  always_comb begin
    abs_x = gx_q[10] ? (~gx_q + 11'd1) : gx_q;
    abs_y = gy_q[10] ? (~gy_q + 11'd1) : gy_q;
    sum_d = abs_x + abs_y;
  end

  // Stage 4: hr_q[2] becomes the output href on the same edge.
  always_comb begin
    mag_d = 8'd0;
    bit_d = 1'b0;
    if (hr_q[2]) begin
      mag_d = (sum_q > 11'd255) ? 8'hff : sum_q[7:0];
      bit_d = (sum_q >= {3'b000, thr_q});
    end
  end

  always_comb begin
    inc     = hr_q[3] && bit_q;
    cnt_inc = (inc && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
    fall    = pvs_q && !vs_q[3];
    pvs_d   = vs_q[3];
    cnt_d   = fall ? '0 : cnt_inc;
    ec_d    = fall ? cnt_inc : ec_q;
    ecv_d   = fall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q  <= '0;
      hr_q  <= '0;
      thr_q <= DEFAULT_THRESH;
      w11_q <= '0;
      w12_q <= '0;
      w13_q <= '0;
      w21_q <= '0;
      w23_q <= '0;
      w31_q <= '0;
      w32_q <= '0;
      w33_q <= '0;
      gx_q  <= '0;
      gy_q  <= '0;
      sum_q <= '0;
      mag_q <= '0;
      bit_q <= 1'b0;
      cnt_q <= '0;
      ec_q  <= '0;
      ecv_q <= 1'b0;
      pvs_q <= 1'b0;
    end else begin
      vs_q  <= vs_d;
      hr_q  <= hr_d;
      thr_q <= thr_d;
      w11_q <= w11_d;
      w12_q <= w12_d;
      w13_q <= w13_d;
      w21_q <= w21_d;
      w23_q <= w23_d;
      w31_q <= w31_d;
      w32_q <= w32_d;
      w33_q <= w33_d;
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      sum_q <= sum_d;
      mag_q <= mag_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
      ec_q  <= ec_d;
      ecv_q <= ecv_d;
      pvs_q <= pvs_d;
    end
  end

  assign post_img_vsync   = vs_q[3];
  assign post_img_href    = hr_q[3];
  assign post_img_mag     = mag_q;
  assign post_img_bit     = bit_q;
  assign edge_count       = ec_q;
  assign edge_count_valid = ecv_q;

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Directed bench for sobel_edge_detect: expected outputs are queued as each window is driven
// and compared four cycles later; a small frame model tracks edge_count/edge_count_valid.
module tb_sobel_edge_detect;

  localparam int unsigned CNT_W = 20;

  logic clk = 1'b0;
  logic rst;
  logic vsync, href, top_f, bot_f, left_f, right_f;
  logic [7:0] threshold;
  logic [7:0] win [9];
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic post_vsync, post_href, post_bit, ec_valid;
  logic [7:0] post_mag;
  logic [CNT_W-1:0] edge_count;

  always #5 clk = ~clk;

  sobel_edge_detect #(
    .DEFAULT_THRESH(8'd80),
    .CNT_W         (CNT_W)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .matrix_img_vsync       (vsync),
    .matrix_img_href        (href),
    .matrix_top_edge_flag   (top_f),
    .matrix_bottom_edge_flag(bot_f),
    .matrix_left_edge_flag  (left_f),
    .matrix_right_edge_flag (right_f),
    .matrix_p11             (p11),
    .matrix_p12             (p12),
    .matrix_p13             (p13),
    .matrix_p21             (p21),
    .matrix_p22             (p22),
    .matrix_p23             (p23),
    .matrix_p31             (p31),
    .matrix_p32             (p32),
    .matrix_p33             (p33),
    .threshold              (threshold),
    .post_img_vsync         (post_vsync),
    .post_img_href          (post_href),
    .post_img_mag           (post_mag),
    .post_img_bit           (post_bit),
    .edge_count             (edge_count),
    .edge_count_valid       (ec_valid)
  );

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] mag;
    logic       bt;
  } exp_t;

  exp_t sbq[$];
  exp_t prev_rec;
  int   errors = 0;
  int   checks = 0;
  int   m_thr, m_cnt, m_ec;
  logic m_vsin, m_pvs, m_valid;
  int   pulses = 0;
  int   ec_log[$];
  int   p0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Border handling modelled by clamping the row/column index to the centre.
  function automatic int model_sum();
    int q[3][3];
    int rr, cc, gx, gy, wgt;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        rr = ((r == 0 && top_f) || (r == 2 && bot_f)) ? 1 : r;
        cc = ((c == 0 && left_f) || (c == 2 && right_f)) ? 1 : c;
        q[r][c] = int'(win[rr*3+cc]);
      end
    end
    gx = 0;
    gy = 0;
    for (int i = 0; i < 3; i++) begin
      wgt = (i == 1) ? 2 : 1;
      gx += wgt * (q[i][2] - q[i][0]);
      gy += wgt * (q[2][i] - q[0][i]);
    end
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  task automatic set_cols(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int r = 0; r < 3; r++) begin
      win[r*3] = a;
      win[r*3+1] = b;
      win[r*3+2] = c;
    end
  endtask

  task automatic set_rows(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int k = 0; k < 3; k++) begin
      win[k] = a;
      win[3+k] = b;
      win[6+k] = c;
    end
  endtask

  task automatic set_flags(input logic t, input logic b, input logic l, input logic r);
    top_f = t;
    bot_f = b;
    left_f = l;
    right_f = r;
  endtask

  task automatic tick(input logic vs, input logic hr);
    exp_t e;
    int   s, c;
    vsync = vs;
    href  = hr;
    {p11, p12, p13} = {win[0], win[1], win[2]};
    {p21, p22, p23} = {win[3], win[4], win[5]};
    {p31, p32, p33} = {win[6], win[7], win[8]};
    if (vs && !m_vsin) m_thr = int'(threshold);
    m_vsin = vs;
    s = model_sum();
    e.vs  = vs;
    e.hr  = hr;
    e.mag = hr ? ((s > 255) ? 8'hff : 8'(s)) : 8'h00;
    e.bt  = hr && (s >= m_thr);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("post_vsync", post_vsync, e.vs);
    chk("post_href", post_href, e.hr);
    chk("post_mag", post_mag, e.mag);
    chk("post_bit", post_bit, e.bt);
    c = m_cnt + ((prev_rec.hr && prev_rec.bt) ? 1 : 0);
    if (m_pvs && !prev_rec.vs) begin
      m_ec = c;
      m_valid = 1'b1;
      m_cnt = 0;
    end else begin
      m_valid = 1'b0;
      m_cnt = c;
    end
    m_pvs = prev_rec.vs;
    prev_rec = e;
    chk("edge_count", edge_count, m_ec);
    chk("edge_count_valid", ec_valid, m_valid);
    if (ec_valid === 1'b1) begin
      pulses++;
      ec_log.push_back(int'(edge_count));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vsync = 1'b0;
    href = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_vsync", post_vsync, 1'b0);
    chk("rst_href", post_href, 1'b0);
    chk("rst_mag", post_mag, 8'd0);
    chk("rst_bit", post_bit, 1'b0);
    chk("rst_edge_count", edge_count, 0);
    chk("rst_valid", ec_valid, 1'b0);
    sbq.delete();
    repeat (3) sbq.push_back('0);
    prev_rec = '0;
    m_thr = 80;
    m_cnt = 0;
    m_ec = 0;
    m_vsin = 1'b0;
    m_pvs = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic frame_open();
    repeat (2) tick(1'b1, 1'b0);
  endtask

  task automatic frame_close(input int gap);
    tick(1'b1, 1'b0);
    repeat (gap) tick(1'b0, 1'b0);
  endtask

  initial begin
    threshold = 8'd80;
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    set_cols(8'h40, 8'h40, 8'h40);
    do_reset();
    repeat (2) tick(1'b0, 1'b0);

    // Flat field
    p0 = pulses;
    frame_open();
    repeat (10) tick(1'b1, 1'b1);
    frame_close(7);
    chk("flat_pulses", pulses - p0, 1);
    chk("flat_count", ec_log[$], 0);

    // Vertical step and opposing column flags
    frame_open();
    set_cols(8'd0, 8'd50, 8'd100);
    repeat (2) tick(1'b1, 1'b1);
    set_flags(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    frame_close(3);

    // Threshold boundary: sum = 40
    set_cols(8'd10, 8'd15, 8'd20);
    frame_open();
    repeat (2) tick(1'b1, 1'b1);
    frame_close(2);
    threshold = 8'd40;
    tick(1'b0, 1'b0);
    frame_open();
    repeat (2) tick(1'b1, 1'b1);
    threshold = 8'd200;
    repeat (3) tick(1'b1, 1'b1);
    frame_close(2);
    threshold = 8'd80;
    repeat (2) tick(1'b0, 1'b0);

    // Border replication
    frame_open();
    set_rows(8'd255, 8'd0, 8'd0);
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) tick(1'b1, 1'b1);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick(1'b1, 1'b1);
    win[3] = 8'd255;
    win[6] = 8'd255;
    set_flags(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) tick(1'b1, 1'b1);
    set_flags(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    frame_close(7);

    // Counting: 3 edges, then back-to-back 0-edge frame with a 1-cycle gap
    p0 = pulses;
    frame_open();
    for (int i = 0; i < 8; i++) begin
      if (i == 1 || i == 4 || i == 6) set_cols(8'd0, 8'd50, 8'd100);
      else set_cols(8'h40, 8'h40, 8'h40);
      tick(1'b1, 1'b1);
    end
    frame_close(1);
    set_cols(8'h40, 8'h40, 8'h40);
    frame_open();
    repeat (5) tick(1'b1, 1'b1);
    frame_close(7);
    chk("count_pulses", pulses - p0, 2);
    chk("count_three", ec_log[$-1], 3);
    chk("count_zero", ec_log[$], 0);

    // Reset mid-frame, then a fresh frame with 2 edges
    frame_open();
    set_cols(8'd0, 8'd50, 8'd100);
    repeat (3) tick(1'b1, 1'b1);
    p0 = pulses;
    do_reset();
    set_cols(8'h40, 8'h40, 8'h40);
    repeat (6) tick(1'b0, 1'b0);
    chk("rst_no_pulse", pulses - p0, 0);
    frame_open();
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || i == 5) set_cols(8'd100, 8'd50, 8'd0);
      else set_cols(8'h40, 8'h40, 8'h40);
      tick(1'b1, 1'b1);
    end
    frame_close(7);
    chk("post_rst_pulses", pulses - p0, 1);
    chk("post_rst_count", ec_log[$], 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_edge_detect.md
Name: sobel_edge_detect

Overview:
- Consumes the 3x3 window stream from the upstream line-buffer/matrix stage (matrix_* signals with border flags).
- Computes the Sobel gradient magnitude |Gx|+|Gy| per pixel and thresholds it into a binary edge map.
- Counts edge pixels per frame for the host/statistics path.
- Border pixels are handled by row/column replication driven by the upstream edge flags; the output is a sync-aligned pixel stream for the binarised-image consumer.

Parameters:
- DEFAULT_THRESH, 8'd80, threshold value loaded at reset.
- CNT_W, 20, width of the per-frame edge-pixel counter (covers 640*480).

Ports:
- clk  in  1  single system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- matrix_img_vsync  in  1  frame-valid from matrix stage.
- matrix_img_href  in  1  pixel-valid from matrix stage.
- matrix_top_edge_flag  in  1  current window row 1 is outside the image.
- matrix_bottom_edge_flag  in  1  row 3 is outside the image.
- matrix_left_edge_flag  in  1  column 1 is outside the image.
- matrix_right_edge_flag  in  1  column 3 is outside the image.
- matrix_p11..matrix_p33  in  8 each  window pixels; pRC = row R, column C; p22 is the centre.
- threshold  in  8  edge threshold requested by software.
- post_img_vsync  out  1  matrix_img_vsync delayed 4 cycles.
- post_img_href  out  1  matrix_img_href delayed 4 cycles.
- post_img_mag  out  8  saturated gradient magnitude.
- post_img_bit  out  1  edge decision.
- edge_count  out  CNT_W  edge pixels in the last completed frame.
- edge_count_valid  out  1  one-cycle pulse when edge_count updates.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - All outputs 0; pipeline and sync delay lines cleared.
  - Frame counter 0; threshold register = DEFAULT_THRESH.
  - Reset mid-frame discards the frame in flight; no edge_count_valid pulse for it.
- Threshold latch: the threshold register loads `threshold` on the rising edge of matrix_img_vsync (registered vsync 0->1). Changes mid-frame are ignored until the next frame.
- Stage 1 (padding register):
  - Row1 := row2 if top flag; row3 := row2 if bottom flag.
  - Then col1 := col2 if left flag; col3 := col2 if right flag.
  - Column substitution applies after row substitution, so corners replicate the centre-adjacent value.
  - Top+bottom both set: both rows take row2, so Gy=0. Left+right both set: Gx=0.
- Stage 2:
  - Gx = (p13+2p23+p33) - (p11+2p21+p31); Gy = (p31+2p32+p33) - (p11+2p12+p13).
  - Signed 11-bit, range ±1020; no overflow.
- Stage 3: sum = |Gx|+|Gy|, unsigned 11-bit, range 0..2040.
- Stage 4 (outputs):
  - post_img_mag = (sum>255) ? 255 : sum[7:0].
  - post_img_bit = (sum >= thr_reg), compared at full 11-bit width against the zero-extended threshold.
  - When the stage-4 href is 0, mag and bit are forced to 0.
- Latency: exactly 4 clk from matrix_* inputs to post_img_*. vsync and href pass through 4-deep shift registers.
- Stage data registers update every cycle; no stall or back-pressure.
- Edge counter:
  - Increments on each cycle with post_img_href=1 and post_img_bit=1.
  - Saturates at 2^CNT_W-1, with no wrap.
- Frame end: on the cycle after post_img_vsync falls (registered 1->0):
  - edge_count loads the counter value, including any increment in that same cycle.
  - edge_count_valid=1 for exactly one cycle.
  - The counter clears to 0.
- edge_count holds its value between frames.
- Back-to-back frames with a 1-cycle vsync gap are supported; the count never bleeds into the next frame.

Test Plan:
- Flat field: all p=0x40, no flags, 10 href cycles -> mag=0, bit=0; at frame end edge_count=0, valid pulses once.
- Vertical step: col1=0, col3=100, col2=50, thr=80 -> Gx=400, Gy=0, mag=255, bit=1, appearing exactly 4 cycles after input. Also check href/vsync aligned at the same cycle.
- Threshold boundary: col1=10, col3=20 -> sum=40. thr=80 gives bit=0, mag=40. Set thr=40 before the vsync rise -> bit=1. Change thr to 200 mid-frame -> bit stays 1 for that frame.
- Border replication: row1=255, rows 2/3=0.
  - top flag=1 -> mag=0, bit=0.
  - Same window with no flag -> Gy=-1020, mag=255, bit=1.
  - left+top flags on a corner pixel -> no spurious edge.
- Counting: a frame with exactly 3 pixels over threshold -> edge_count=3, edge_count_valid high 1 cycle after post_img_vsync falls. The next frame of 0 edges -> edge_count=0.
- Reset mid-frame: assert rst for 1 cycle during href -> all outputs 0 next cycle, no valid pulse. The next full frame counts correctly from 0.
